// File: rtl/jam_pkg.sv
// Shared types and constants for the job-assignment host: matrix geometry, FSM states,
// error-bit positions and the cost LFSR polynomial.
package jam_pkg;

   localparam int N_JOB  = 8;
   localparam int N_COST = 64;
   localparam int COST_W = 7;
   localparam int JOB_W  = 4;
   localparam int SUM_W  = 10;
   localparam int ERR_W  = 5;

   localparam int ERR_TIMEOUT = 0;
   localparam int ERR_LENGTH  = 1;
   localparam int ERR_RANGE   = 2;
   localparam int ERR_DUP     = 3;
   localparam int ERR_COST    = 4;

   // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: taps at bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS         = 16'h002D;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEND  = 3'd1,
      GAP   = 3'd2,
      WAIT  = 3'd3,
      RECV  = 3'd4,
      CHECK = 3'd5,
      DONE  = 3'd6
   } state_e;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/jam_cost_lfsr.sv
// 16-bit Fibonacci LFSR producing pseudo-random cost words; a zero seed is replaced by SEED
// so the register can never lock up in the all-zero state.
module jam_cost_lfsr
   import jam_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [15:0]       seed_i,
   input  logic              step_i,
   output logic [COST_W-1:0] cost_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;
   logic [15:0] base_s;

   // Value seen this cycle is the freshly loaded seed on a load, so beat 0 needs no extra cycle.
   always_comb begin
      if (load_i) begin
         base_s = (seed_i == 16'h0000) ? SEED : seed_i;
      end else begin
         base_s = state_q;
      end
      if (step_i) begin
         state_d = lfsr_next(base_s);
      end else begin
         state_d = base_s;
      end
   end

   assign cost_o = base_s[COST_W-1:0];

   // LFSR state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/jam_host.sv
// Driving end of the job-assignment solver: streams an 8x8 cost matrix, captures the
// 8-beat answer, recomputes its cost from the local table and flags inconsistencies.
module jam_host
   import jam_pkg::*;
#(
   parameter int unsigned          TIMEOUT_W = 20,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 20'hFFFFF,
   parameter logic [15:0]          LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              src_sel,
   input  logic [15:0]       seed,
   input  logic              wr_en,
   input  logic [5:0]        wr_addr,
   input  logic [COST_W-1:0] wr_data,
   output logic              in_valid,
   output logic [COST_W-1:0] in_cost,
   input  logic              out_valid,
   input  logic [JOB_W-1:0]  out_job,
   input  logic [SUM_W-1:0]  out_cost,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err,
   output logic [SUM_W-1:0]  res_cost
);

   localparam logic [6:0] IDX_END = 7'd64;

   state_e               state_q;
   logic [6:0]           idx_q;
   logic [2:0]           rbeat_q;
   logic [TIMEOUT_W-1:0] tmo_q;
   logic [N_JOB-1:0]     mask_q;
   logic [SUM_W-1:0]     sum_q;
   logic [SUM_W-1:0]     cost0_q;
   logic                 src_q;
   logic                 in_valid_q;
   logic [COST_W-1:0]    in_cost_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 pass_q;
   logic [ERR_W-1:0]     err_q;
   logic [SUM_W-1:0]     res_cost_q;
   logic [COST_W-1:0]    table_q [N_COST];

   logic              idle_s;
   logic              start_ok_s;
   logic              emit_s;
   logic              src_now_s;
   logic [COST_W-1:0] lfsr_cost_s;
   logic [COST_W-1:0] beat_cost_s;
   logic              job_ok_s;
   logic [2:0]        job_idx_s;
   logic [5:0]        rd_addr_s;
   logic [COST_W-1:0] rd_data_s;
   logic              tab_we_s;
   logic [5:0]        tab_waddr_s;
   logic [COST_W-1:0] tab_wdata_s;
   logic [ERR_W-1:0]  err_acc_s;
   logic [N_JOB-1:0]  mask_acc_s;
   logic [SUM_W-1:0]  sum_acc_s;
   logic [ERR_W-1:0]  err_chk_s;

   assign idle_s     = (state_q == IDLE) || (state_q == DONE);
   assign start_ok_s = start && idle_s;
   assign emit_s     = start_ok_s || ((state_q == SEND) && (idx_q != IDX_END));
   assign src_now_s  = (state_q == SEND) ? src_q : src_sel;
   assign job_ok_s   = (out_job != 4'd0) && (out_job <= 4'd8);
   assign job_idx_s  = out_job[2:0] - 3'd1;
   assign rd_data_s  = table_q[rd_addr_s];
   assign beat_cost_s = src_now_s ? rd_data_s : lfsr_cost_s;

   jam_cost_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .load_i (start_ok_s),
      .seed_i (seed),
      .step_i (emit_s),
      .cost_o (lfsr_cost_s)
   );

   // Single table read port: streaming index while sending, worker/job cell while receiving.
   always_comb begin
      case (state_q)
         SEND:       rd_addr_s = idx_q[5:0];
         WAIT, RECV: rd_addr_s = {rbeat_q, job_idx_s};
         default:    rd_addr_s = 6'd0;
      endcase
   end

   // Single table write port; a host write outranks the LFSR fill in the start cycle.
   always_comb begin
      if (wr_en && idle_s) begin
         tab_we_s    = 1'b1;
         tab_waddr_s = wr_addr;
         tab_wdata_s = wr_data;
      end else if (emit_s && !src_now_s) begin
         tab_we_s    = 1'b1;
         tab_waddr_s = (state_q == SEND) ? idx_q[5:0] : 6'd0;
         tab_wdata_s = lfsr_cost_s;
      end else begin
         tab_we_s    = 1'b0;
         tab_waddr_s = 6'd0;
         tab_wdata_s = {COST_W{1'b0}};
      end
   end

   // Grade one answer beat; out-of-range jobs contribute neither to the mask nor to the sum.
   always_comb begin
      err_acc_s  = err_q;
      mask_acc_s = mask_q;
      sum_acc_s  = sum_q;
      if (job_ok_s) begin
         if (mask_q[job_idx_s]) begin
            err_acc_s[ERR_DUP] = 1'b1;
         end else begin
            err_acc_s[ERR_DUP] = err_q[ERR_DUP];
         end
         mask_acc_s[job_idx_s] = 1'b1;
         sum_acc_s = sum_q + {3'b000, rd_data_s};
      end else begin
         err_acc_s[ERR_RANGE] = 1'b1;
      end
      if ((state_q == RECV) && (out_cost != cost0_q)) begin
         err_acc_s[ERR_COST] = 1'b1;
      end else begin
         err_acc_s[ERR_COST] = err_q[ERR_COST];
      end
   end

   // Final verdict: a ninth beat or a claimed total that disagrees with the recomputed one.
   always_comb begin
      err_chk_s = err_q;
      if (out_valid) begin
         err_chk_s[ERR_LENGTH] = 1'b1;
      end else begin
         err_chk_s[ERR_LENGTH] = err_q[ERR_LENGTH];
      end
      if (sum_q != cost0_q) begin
         err_chk_s[ERR_COST] = 1'b1;
      end else begin
         err_chk_s[ERR_COST] = err_q[ERR_COST];
      end
   end

   // Cost table storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_COST; i++) begin
            table_q[i] <= {COST_W{1'b0}};
         end
      end else if (tab_we_s) begin
         table_q[tab_waddr_s] <= tab_wdata_s;
      end
   end

   // Sequencer: send matrix, collect answer, grade it; owns every host output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= 7'd0;
         rbeat_q    <= 3'd0;
         tmo_q      <= {TIMEOUT_W{1'b0}};
         mask_q     <= 8'h00;
         sum_q      <= 10'd0;
         cost0_q    <= 10'd0;
         src_q      <= 1'b0;
         in_valid_q <= 1'b0;
         in_cost_q  <= 7'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= 5'd0;
         res_cost_q <= 10'd0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_ok_s) begin
                  state_q    <= SEND;
                  src_q      <= src_sel;
                  in_valid_q <= 1'b1;
                  in_cost_q  <= beat_cost_s;
                  idx_q      <= 7'd1;
                  rbeat_q    <= 3'd0;
                  mask_q     <= 8'h00;
                  sum_q      <= 10'd0;
                  cost0_q    <= 10'd0;
                  err_q      <= 5'd0;
                  res_cost_q <= 10'd0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
               end else begin
                  state_q <= state_q;
               end
            end
            SEND: begin
               if (out_valid) begin
                  err_q[ERR_LENGTH] <= 1'b1;
               end
               if (idx_q == IDX_END) begin
                  in_valid_q <= 1'b0;
                  in_cost_q  <= 7'd0;
                  state_q    <= GAP;
               end else begin
                  in_cost_q <= beat_cost_s;
                  idx_q     <= idx_q + 7'd1;
               end
            end
            GAP: begin
               if (out_valid) begin
                  err_q[ERR_LENGTH] <= 1'b1;
               end
               tmo_q   <= {TIMEOUT_W{1'b0}};
               state_q <= WAIT;
            end
            WAIT: begin
               if (out_valid) begin
                  err_q   <= err_acc_s;
                  mask_q  <= mask_acc_s;
                  sum_q   <= sum_acc_s;
                  cost0_q <= out_cost;
                  rbeat_q <= 3'd1;
                  state_q <= RECV;
               end else if (tmo_q == TIMEOUT) begin
                  err_q[ERR_TIMEOUT] <= 1'b1;
                  res_cost_q <= sum_q;
                  pass_q     <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  tmo_q <= tmo_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
               end
            end
            RECV: begin
               if (out_valid) begin
                  err_q   <= err_acc_s;
                  mask_q  <= mask_acc_s;
                  sum_q   <= sum_acc_s;
                  rbeat_q <= rbeat_q + 3'd1;
                  if (rbeat_q == 3'd7) begin
                     state_q <= CHECK;
                  end
               end else begin
                  err_q[ERR_LENGTH] <= 1'b1;
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               err_q      <= err_chk_s;
               pass_q     <= (err_chk_s == 5'd0);
               res_cost_q <= sum_q;
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               state_q    <= DONE;
            end
            default: begin
               state_q    <= IDLE;
               in_valid_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_valid = in_valid_q;
   assign in_cost  = in_cost_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err      = err_q;
   assign res_cost = res_cost_q;

endmodule
